// File: rtl/masked_sbox_layer_ser_if.sv
// Handshake and share bus of the serialised masked PRINCE S-box layer.
interface masked_sbox_layer_ser_if #(
   parameter int unsigned STATE_W = 64,
   parameter int unsigned N_CORES = 4
);
   localparam int unsigned RND_W = 16 * N_CORES;

   logic               in_valid;
   logic               in_ready;
   logic [STATE_W-1:0] in_x;
   logic [STATE_W-1:0] in_y;
   logic               in_sel;
   logic [RND_W-1:0]   rnd;
   logic               rnd_req;
   logic               out_valid;
   logic               out_ready;
   logic [STATE_W-1:0] out_x;
   logic [STATE_W-1:0] out_y;
   logic               busy;

   // Producer/consumer side driving the layer.
   modport master (
      output in_valid, in_x, in_y, in_sel, rnd, out_ready,
      input  in_ready, rnd_req, out_valid, out_x, out_y, busy
   );

   // The S-box layer itself.
   modport slave (
      input  in_valid, in_x, in_y, in_sel, rnd, out_ready,
      output in_ready, rnd_req, out_valid, out_x, out_y, busy
   );
endinterface

// File: rtl/masked_sbox_layer_ser.sv
// First-order GLM-masked PRINCE S-box layer, N_CORES nibbles per cycle over two shares.
module masked_sbox_layer_ser #(
   parameter int unsigned STATE_W = 64,
   parameter int unsigned N_CORES = 4
) (
   input logic                     clk,
   input logic                     rst,
   masked_sbox_layer_ser_if.slave  bus
);

   localparam int unsigned GW    = 4 * N_CORES;
   localparam int unsigned G     = STATE_W / GW;
   localparam int unsigned RND_W = 16 * N_CORES;
   localparam int unsigned TW    = 4 * GW;
   localparam int unsigned CW    = (G > 1) ? $clog2(G) : 1;

   // Nibble a of the table sits at bits [4a+3:4a].
   localparam logic [63:0] SBOX_FWD = 64'h4D5E087619CA23FB;
   localparam logic [63:0] SBOX_INV = 64'h1CE5046A98DF237B;

   // Algebraic normal form of each output bit; bit b occupies [16b+15:16b].
   function automatic logic [63:0] anf_table(input logic [63:0] tbl);
      logic [63:0] r;
      logic [15:0] tt;
      r  = '0;
      tt = '0;
      for (int b = 0; b < 4; b++) begin
         for (int a = 0; a < 16; a++) tt[a] = tbl[4*a+b];
         for (int i = 0; i < 4; i++)
            for (int a = 0; a < 16; a++)
               if (a[i]) tt[a] = tt[a] ^ tt[a ^ (1 << i)];
         r[16*b +: 16] = tt;
      end
      return r;
   endfunction

   // Share-selected cross terms of one domain: variable i is taken from y when s[i], else x.
   function automatic logic dom(input logic [15:0] anf, input logic [3:0] s,
                                input logic [3:0] x, input logic [3:0] y);
      logic acc;
      logic p;
      acc = 1'b0;
      for (int m = 0; m < 16; m++) begin
         if (anf[m] && ((s & ~4'(m)) == 4'd0)) begin
            p = 1'b1;
            for (int i = 0; i < 4; i++)
               if (m[i]) p = p & (s[i] ? y[i] : x[i]);
            acc = acc ^ p;
         end
      end
      return acc;
   endfunction

   localparam logic [63:0] ANF_FWD = anf_table(SBOX_FWD);
   localparam logic [63:0] ANF_INV = anf_table(SBOX_INV);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

   state_t             state, state_d;
   logic [CW-1:0]      cnt;
   logic               sel_q;
   logic [STATE_W-1:0] sh_x, sh_y;
   logic [STATE_W-1:0] res_x, res_y;
   logic [TW-1:0]      term_x, term_y;
   logic [TW-1:0]      cq_x, cq_y;
   logic [GW-1:0]      core_x, core_y;
   logic [RND_W-1:0]   rnd_s;
   logic               in_ready_d, rnd_req_d, out_valid_d, busy_d;
   logic               in_ready_q, rnd_req_q, out_valid_q, busy_q;

   assign rnd_s = bus.rnd;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_d;
   end

   // Next-state logic: IDLE -> RUN (G groups) -> FLUSH -> DONE -> IDLE.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (bus.in_valid) state_d = RUN;
         RUN:     if (cnt == CW'(G - 1)) state_d = FLUSH;
         FLUSH:   state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the next state so the registered flags track the state exactly.
   always_comb begin
      in_ready_d  = (state_d == IDLE);
      rnd_req_d   = (state_d == RUN);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // Registered handshake flags; in_ready comes out of reset high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready_q  <= 1'b1;
         rnd_req_q   <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         in_ready_q  <= in_ready_d;
         rnd_req_q   <= rnd_req_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Domain functions and remasking: x-half uses domains 0..3, y-half 4..7, same 4 random bits.
   always_comb begin
      logic [3:0] xn, yn;
      logic       tf, ti, t;
      xn     = '0;
      yn     = '0;
      tf     = 1'b0;
      ti     = 1'b0;
      t      = 1'b0;
      term_x = '0;
      term_y = '0;
      for (int k = 0; k < int'(N_CORES); k++) begin
         xn = sh_x[4*k +: 4];
         yn = sh_y[4*k +: 4];
         for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 8; j++) begin
               tf = dom(ANF_FWD[16*b +: 16], 4'(j), xn, yn) ^
                    dom(ANF_FWD[16*b +: 16], 4'(j + 8), xn, yn);
               ti = dom(ANF_INV[16*b +: 16], 4'(j), xn, yn) ^
                    dom(ANF_INV[16*b +: 16], 4'(j + 8), xn, yn);
               t  = sel_q ? tf : ti;
               if (j < 4) term_x[16*k + 4*b + j]     = t ^ rnd_s[16*k + 4*b + j];
               else       term_y[16*k + 4*b + j - 4] = t ^ rnd_s[16*k + 4*b + j - 4];
            end
         end
      end
   end

   // Core output registers, loaded only while fresh randomness is being consumed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cq_x <= '0;
         cq_y <= '0;
      end else if (state == RUN) begin
         cq_x <= term_x;
         cq_y <= term_y;
      end
   end

   // XOR-4 compression of the registered terms, separately per share.
   always_comb begin
      core_x = '0;
      core_y = '0;
      for (int n = 0; n < int'(GW); n++) begin
         core_x[n] = ^cq_x[4*n +: 4];
         core_y[n] = ^cq_y[4*n +: 4];
      end
   end

   // Share shift registers, group counter, mode latch and result assembly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_x  <= '0;
         sh_y  <= '0;
         res_x <= '0;
         res_y <= '0;
         cnt   <= '0;
         sel_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sh_x  <= bus.in_x;
                  sh_y  <= bus.in_y;
                  sel_q <= bus.in_sel;
                  cnt   <= '0;
               end
            end
            RUN: begin
               sh_x <= sh_x >> GW;
               sh_y <= sh_y >> GW;
               cnt  <= cnt + CW'(1);
               if (cnt != '0) begin
                  res_x <= (res_x >> GW) | (STATE_W'(core_x) << (STATE_W - GW));
                  res_y <= (res_y >> GW) | (STATE_W'(core_y) << (STATE_W - GW));
               end
            end
            FLUSH: begin
               res_x <= (res_x >> GW) | (STATE_W'(core_x) << (STATE_W - GW));
               res_y <= (res_y >> GW) | (STATE_W'(core_y) << (STATE_W - GW));
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.rnd_req   = rnd_req_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.out_x     = res_x;
   assign bus.out_y     = res_y;

endmodule

// File: tb/tb_masked_sbox_layer_ser.sv
// Self-checking bench for the serialised masked PRINCE S-box layer.
module tb_masked_sbox_layer_ser;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   masked_sbox_layer_ser_if #(.STATE_W(64), .N_CORES(4))  b ();
   masked_sbox_layer_ser_if #(.STATE_W(64), .N_CORES(1))  b1 ();
   masked_sbox_layer_ser_if #(.STATE_W(64), .N_CORES(16)) b16 ();

   masked_sbox_layer_ser #(.STATE_W(64), .N_CORES(4))  dut   (.clk(clk), .rst(rst), .bus(b));
   masked_sbox_layer_ser #(.STATE_W(64), .N_CORES(1))  dut1  (.clk(clk), .rst(rst), .bus(b1));
   masked_sbox_layer_ser #(.STATE_W(64), .N_CORES(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

   typedef struct {
      logic [63:0] plain;
      logic [63:0] xs;
      logic        sel;
      logic [63:0] exp;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] sb [$];
   vec_t        tv [10];
   logic [63:0] oa, ob, ox, oy, p, e, xa;
   int          n, lat1, lat16;

   // Fresh randomness every cycle on all instances.
   always @(negedge clk) begin
      b.rnd  = {$urandom, $urandom};
      b1.rnd = 16'($urandom);
      for (int i = 0; i < 8; i++) b16.rnd[32*i +: 32] = $urandom;
   end

   function automatic logic [3:0] s_fwd(input logic [3:0] a);
      case (a)
         4'h0: return 4'hB;  4'h1: return 4'hF;  4'h2: return 4'h3;  4'h3: return 4'h2;
         4'h4: return 4'hA;  4'h5: return 4'hC;  4'h6: return 4'h9;  4'h7: return 4'h1;
         4'h8: return 4'h6;  4'h9: return 4'h7;  4'hA: return 4'h8;  4'hB: return 4'h0;
         4'hC: return 4'hE;  4'hD: return 4'h5;  4'hE: return 4'hD;  default: return 4'h4;
      endcase
   endfunction

   function automatic logic [3:0] s_inv(input logic [3:0] a);
      for (int v = 0; v < 16; v++)
         if (s_fwd(4'(v)) == a) return 4'(v);
      return 4'h0;
   endfunction

   function automatic logic [63:0] ref_layer(input logic [63:0] pl, input logic sel);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         r[4*i +: 4] = sel ? s_fwd(pl[4*i +: 4]) : s_inv(pl[4*i +: 4]);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Offer one state (called #1 after an edge); returns #1 after the accepting edge.
   task automatic send(input logic [63:0] x, input logic [63:0] y, input logic sel,
                       input logic [63:0] exp);
      int k;
      k = 0;
      b.in_x = x; b.in_y = y; b.in_sel = sel; b.in_valid = 1'b1;
      while (!b.in_ready && k < 50) begin @(posedge clk); #1; k++; end
      chk("accept_ready", 64'(b.in_ready), 64'd1);
      @(posedge clk); #1;
      b.in_valid = 1'b0;
      b.in_x = {$urandom, $urandom};
      b.in_y = {$urandom, $urandom};
      sb.push_back(exp);
   endtask

   // Wait for the result, check latency/randomness use/result, optionally stall, then handshake.
   task automatic recv(input int hold, output logic [63:0] rx);
      int          k, rq;
      logic [63:0] ex, hx, hy;
      k  = 0;
      rq = int'(b.rnd_req);
      while (!b.out_valid && k < 100) begin @(posedge clk); #1; k++; rq += int'(b.rnd_req); end
      chk("latency", 64'(k), 64'd5);
      chk("rnd_req_cycles", 64'(rq), 64'd4);
      if (sb.size() == 0) begin
         bad++; total++;
         $display("FAIL scoreboard_empty: got 0 entries, required 1");
         ex = '0;
      end else ex = sb.pop_front();
      chk("result", b.out_x ^ b.out_y, ex);
      rx = b.out_x;
      hx = b.out_x;
      hy = b.out_y;
      repeat (hold) begin @(posedge clk); #1; end
      if (hold > 0) begin
         chk("hold_x", b.out_x, hx);
         chk("hold_y", b.out_y, hy);
         chk("hold_valid", 64'(b.out_valid), 64'd1);
      end
      b.out_ready = 1'b1;
      @(posedge clk); #1;
      b.out_ready = 1'b0;
      chk("idle_after_hs", 64'({b.in_ready, b.out_valid, b.busy}), 64'b100);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      b.in_valid = 0;  b.in_x = '0;  b.in_y = '0;  b.in_sel = 0;  b.out_ready = 0;
      b1.in_valid = 0; b1.in_x = '0; b1.in_y = '0; b1.in_sel = 0; b1.out_ready = 0;
      b16.in_valid = 0; b16.in_x = '0; b16.in_y = '0; b16.in_sel = 0; b16.out_ready = 0;
      b.rnd = '0; b1.rnd = '0; b16.rnd = '0;

      tv[0] = '{64'h0123456789ABCDEF, 64'h0, 1'b1, 64'hBF32AC916780E5D4};
      tv[1] = '{64'hBF32AC916780E5D4, 64'hA5A5A5A5A5A5A5A5, 1'b0, 64'h0123456789ABCDEF};
      tv[2] = '{64'h0, {$urandom, $urandom}, 1'b1, 64'hBBBBBBBBBBBBBBBB};
      tv[3] = '{64'h0, {$urandom, $urandom}, 1'b0, 64'hBBBBBBBBBBBBBBBB};
      tv[4] = '{64'hFFFFFFFFFFFFFFFF, {$urandom, $urandom}, 1'b1, 64'h4444444444444444};
      tv[5] = '{64'hFFFFFFFFFFFFFFFF, {$urandom, $urandom}, 1'b0, 64'h1111111111111111};
      tv[6] = '{64'hFEDCBA9876543210, {$urandom, $urandom}, 1'b1, 64'h4D5E087619CA23FB};
      tv[7] = '{64'h0123456789ABCDEF, {$urandom, $urandom}, 1'b0, 64'hB732FD89A6405EC1};
      p = {$urandom, $urandom};
      tv[8] = '{p, {$urandom, $urandom}, 1'b1, ref_layer(p, 1'b1)};
      p = {$urandom, $urandom};
      tv[9] = '{p, {$urandom, $urandom}, 1'b0, ref_layer(p, 1'b0)};

      // Reset values.
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("reset_flags", 64'({b.in_ready, b.out_valid, b.busy, b.rnd_req}), 64'b1000);
      chk("reset_out_x", b.out_x, 64'h0);
      chk("reset_out_y", b.out_y, 64'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // Table-driven layers, with varying output stalls.
      for (int i = 0; i < 10; i++) begin
         send(tv[i].xs, tv[i].xs ^ tv[i].plain, tv[i].sel, tv[i].exp);
         recv(i % 3, oa);
      end

      // Same input twice: shares re-randomised, unmasked value identical.
      send(64'h0, 64'h0123456789ABCDEF, 1'b1, 64'hBF32AC916780E5D4);
      recv(0, oa);
      send(64'h0, 64'h0123456789ABCDEF, 1'b1, 64'hBF32AC916780E5D4);
      recv(0, ob);
      total++;
      if (oa === ob) begin
         bad++;
         $display("FAIL rerandomised_out_x: got %h twice, required differing shares", oa);
      end

      // Output stall of 10 cycles with a competing input offer.
      send(64'h0, 64'h0123456789ABCDEF, 1'b1, 64'hBF32AC916780E5D4);
      n = 0;
      while (!b.out_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("stall_latency", 64'(n), 64'd5);
      e = sb.pop_front();
      chk("stall_result", b.out_x ^ b.out_y, e);
      ox = b.out_x; oy = b.out_y;
      xa = 64'hA5A5A5A5A5A5A5A5;
      b.in_x = xa; b.in_y = xa ^ 64'hBF32AC916780E5D4; b.in_sel = 1'b0; b.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("stall_flags", 64'({b.out_valid, b.in_ready, b.rnd_req, b.busy}), 64'b1001);
         chk("stall_out", {b.out_x ^ ox} | {b.out_y ^ oy}, 64'h0);
      end
      b.out_ready = 1'b1;
      @(posedge clk); #1;
      b.out_ready = 1'b0;
      chk("stall_released", 64'({b.in_ready, b.busy, b.out_valid}), 64'b100);
      @(posedge clk); #1;
      chk("stall_accepted", 64'({b.in_ready, b.busy}), 64'b01);
      b.in_valid = 1'b0;
      sb.push_back(64'h0123456789ABCDEF);
      recv(0, oa);

      // Reset pulse in the middle of RUN (cnt=2).
      send(64'h0, 64'h0123456789ABCDEF, 1'b1, 64'hBF32AC916780E5D4);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midrun_reset_flags", 64'({b.out_valid, b.in_ready, b.busy, b.rnd_req}), 64'b0100);
      chk("midrun_reset_out", b.out_x | b.out_y, 64'h0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      p = {$urandom, $urandom};
      xa = {$urandom, $urandom};
      send(xa, xa ^ p, 1'b1, ref_layer(p, 1'b1));
      recv(1, oa);

      // Narrow and wide instances on the same vector.
      xa = {$urandom, $urandom};
      b1.in_x = xa;  b1.in_y = xa ^ 64'h0123456789ABCDEF;  b1.in_sel = 1'b1;
      b16.in_x = xa; b16.in_y = xa ^ 64'h0123456789ABCDEF; b16.in_sel = 1'b1;
      b1.in_valid = 1'b1; b16.in_valid = 1'b1;
      chk("sweep_ready", 64'({b1.in_ready, b16.in_ready}), 64'b11);
      @(posedge clk); #1;
      b1.in_valid = 1'b0; b16.in_valid = 1'b0;
      n = 0; lat1 = -1; lat16 = -1;
      while ((lat1 < 0 || lat16 < 0) && n < 40) begin
         @(posedge clk); #1; n++;
         if (lat1 < 0 && b1.out_valid)   lat1 = n;
         if (lat16 < 0 && b16.out_valid) lat16 = n;
      end
      chk("n1_latency", 64'(lat1), 64'd17);
      chk("n16_latency", 64'(lat16), 64'd2);
      chk("n1_result", b1.out_x ^ b1.out_y, 64'hBF32AC916780E5D4);
      chk("n16_result", b16.out_x ^ b16.out_y, 64'hBF32AC916780E5D4);
      b1.out_ready = 1'b1; b16.out_ready = 1'b1;
      @(posedge clk); #1;
      b1.out_ready = 1'b0; b16.out_ready = 1'b0;
      chk("sweep_idle", 64'({b1.in_ready, b1.out_valid, b16.in_ready, b16.out_valid}), 64'b1010);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
